// File: rtl/uart_cmd_rx_if.sv
// CPU UART load port: command select and data with a one-cycle load strobe.
//
// Handshake: uart_en is a valid-only strobe with no ready/backpressure. While
// uart_en is high for one clk, uart_sel/uart_data carry a new command that the
// consumer must take in that cycle; outside a strobe both are stable.
interface uart_cmd_rx_if;
    logic        uart_en;
    logic [1:0]  uart_sel;
    logic [15:0] uart_data;

    modport master (output uart_en, output uart_sel, output uart_data);
    modport slave  (input  uart_en, input  uart_sel, input  uart_data);
endinterface

// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8N1 bytes on rx are assembled into 3-byte frames
// (header, data-high, data-low). A good frame produces one uart_en strobe with
// the new uart_sel/uart_data; bad, broken or stalled frames are dropped and
// flagged with a one-cycle error pulse. Both FSM states are exposed for debug.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_CLKS = 8700
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_cmd_rx_if.master  cmd,
    output logic           busy,
    output logic           frm_err,
    output logic           hdr_err,
    output logic           to_err,
    output logic [1:0]     bit_fsm_state,
    output logic [1:0]     frame_fsm_state
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
    typedef enum logic [1:0] {F_HDR, F_HI, F_LO} frame_state_t;

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [5:0]    HDR_TAG   = 6'b101000;

    // Synchroniser
    logic rx_meta;
    logic rxs;

    // Bit FSM
    bit_state_t    bit_state, bit_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, idx_next;
    logic [7:0]    shreg, sh_next;
    logic          byte_done;
    logic          stop_bad;
    logic          start_det;

    // Frame FSM
    frame_state_t  frame_state, frame_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic          hdr_bad;
    logic          timeout;
    logic          latch_sel;
    logic          latch_hi;
    logic          fire;
    logic [1:0]    sel_q;
    logic [7:0]    hi_q;

    assign bit_fsm_state   = bit_state;
    assign frame_fsm_state = frame_state;

    // Two-flop synchroniser for the asynchronous rx line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Bit FSM state and per-bit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_state <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            bit_state <= bit_next;
            cnt       <= cnt_next;
            bit_idx   <= idx_next;
            shreg     <= sh_next;
        end
    end

    // Bit FSM next state: start-bit qualification, LSB-first shift, stop check.
    always_comb begin
        bit_next  = bit_state;
        cnt_next  = cnt;
        idx_next  = bit_idx;
        sh_next   = shreg;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        start_det = 1'b0;
        case (bit_state)
            IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    bit_next  = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        bit_next = DATA;
                        idx_next = '0;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        bit_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    sh_next  = {rxs, shreg[7:1]};
                    idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        bit_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    // Leave mid-stop-bit so a following start edge is not missed.
                    cnt_next = '0;
                    bit_next = IDLE;
                    if (rxs) begin
                        byte_done = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                bit_next = IDLE;
                cnt_next = '0;
            end
        endcase
    end

    // Frame FSM state and inter-byte timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_state <= F_HDR;
            tcnt        <= '0;
        end else begin
            frame_state <= frame_next;
            tcnt        <= tcnt_next;
        end
    end

    // Frame FSM next state: header check, byte latching, abort on error/timeout.
    always_comb begin
        frame_next = frame_state;
        tcnt_next  = tcnt;
        hdr_bad    = 1'b0;
        timeout    = 1'b0;
        latch_sel  = 1'b0;
        latch_hi   = 1'b0;
        fire       = 1'b0;

        if (stop_bad) begin
            frame_next = F_HDR;
        end else if (byte_done) begin
            case (frame_state)
                F_HDR: begin
                    if (shreg[7:2] == HDR_TAG) begin
                        latch_sel  = 1'b1;
                        frame_next = F_HI;
                    end else begin
                        hdr_bad = 1'b1;
                    end
                end
                F_HI: begin
                    latch_hi   = 1'b1;
                    frame_next = F_LO;
                end
                F_LO: begin
                    fire       = 1'b1;
                    frame_next = F_HDR;
                end
                default: frame_next = F_HDR;
            endcase
        end

        // A byte or start edge restarts the window, so byte_done beats timeout.
        if (byte_done || start_det || frame_state == F_HDR) begin
            tcnt_next = '0;
        end else if (bit_state == IDLE) begin
            if (tcnt == TO_LAST) begin
                timeout    = 1'b1;
                tcnt_next  = '0;
                frame_next = F_HDR;
            end else begin
                tcnt_next = tcnt + 1'b1;
            end
        end
    end

    // Frame payload latches and registered outputs; the command only moves on a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q         <= '0;
            hi_q          <= '0;
            cmd.uart_en   <= 1'b0;
            cmd.uart_sel  <= '0;
            cmd.uart_data <= '0;
            busy          <= 1'b0;
            frm_err       <= 1'b0;
            hdr_err       <= 1'b0;
            to_err        <= 1'b0;
        end else begin
            cmd.uart_en <= fire;
            frm_err     <= stop_bad;
            hdr_err     <= hdr_bad;
            to_err      <= timeout;
            busy        <= (bit_state != IDLE) || (frame_state != F_HDR);
            if (latch_sel) begin
                sel_q <= shreg[1:0];
            end
            if (latch_hi) begin
                hi_q <= shreg;
            end
            if (fire) begin
                cmd.uart_sel  <= sel_q;
                cmd.uart_data <= {hi_q, shreg};
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with CLKS_PER_BIT=16, TIMEOUT_CLKS=640.
// Bytes are driven #1 after a rising edge; a byte whose first (start) edge is
// driven after edge P0 has its stop bit sampled at edge P0+155, so strobes and
// byte-level pulses are seen on the falling edge with cyc == P0+155.
module tb_uart_cmd_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       busy;
    logic       frm_err;
    logic       hdr_err;
    logic       to_err;
    logic [1:0] bit_fsm_state;
    logic [1:0] frame_fsm_state;

    uart_cmd_rx_if cmd_if ();

    uart_cmd_rx #(
        .CLKS_PER_BIT (16),
        .TIMEOUT_CLKS (640)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .cmd             (cmd_if),
        .busy            (busy),
        .frm_err         (frm_err),
        .hdr_err         (hdr_err),
        .to_err          (to_err),
        .bit_fsm_state   (bit_fsm_state),
        .frame_fsm_state (frame_fsm_state)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_start  = 0;

    int en_cnt, en_cyc, frm_cnt, hdr_cnt, hdr_cyc, to_cnt, to_cyc;
    int overlap_cnt = 0;
    int change_cnt  = 0;
    logic [1:0]  en_sel;
    logic [15:0] en_data;
    logic [1:0]  prev_sel  = '0;
    logic [15:0] prev_data = '0;

    // Clock: 100 ns period.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Edge counter used to time strobes and pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (cmd_if.uart_en) begin
            en_cnt++;
            en_cyc  = cyc;
            en_sel  = cmd_if.uart_sel;
            en_data = cmd_if.uart_data;
        end
        if (frm_err) frm_cnt++;
        if (hdr_err) begin
            hdr_cnt++;
            hdr_cyc = cyc;
        end
        if (to_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if ((int'(cmd_if.uart_en) + int'(frm_err) + int'(hdr_err) + int'(to_err)) > 1)
            overlap_cnt++;
        if (!reset && !cmd_if.uart_en &&
            (cmd_if.uart_sel !== prev_sel || cmd_if.uart_data !== prev_data))
            change_cnt++;
        prev_sel  = cmd_if.uart_sel;
        prev_data = cmd_if.uart_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        en_cnt  = 0;
        en_cyc  = 0;
        frm_cnt = 0;
        hdr_cnt = 0;
        hdr_cyc = 0;
        to_cnt  = 0;
        to_cyc  = 0;
    endtask

    // Call #1 after a rising edge; returns #1 after the edge ending the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        last_start = cyc;
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (16) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        clear_mon();

        // Reset state.
        @(negedge clk);
        chk("rst_en",   cmd_if.uart_en,   1'b0);
        chk("rst_sel",  cmd_if.uart_sel,  2'd0);
        chk("rst_data", cmd_if.uart_data, 16'd0);
        chk("rst_busy", busy,             1'b0);
        chk("rst_errs", {frm_err, hdr_err, to_err}, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        idle_clks(5);

        // 1: A1,00,0A back-to-back.
        clear_mon();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0A, 1'b1);
        chk("t1_en_cnt",  en_cnt, 1);
        chk("t1_sel",     en_sel, 2'd1);
        chk("t1_data",    en_data, 16'h000A);
        chk("t1_en_time", en_cyc, last_start + 155);
        chk("t1_errs",    frm_cnt + hdr_cnt + to_cnt, 0);
        idle_clks(3);
        chk("t1_busy",    busy, 1'b0);

        // 2: two frames, outputs hold between strobes.
        clear_mon();
        send_byte(8'hA2, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2C, 1'b1);
        chk("t2a_en_cnt", en_cnt, 1);
        chk("t2a_sel",    en_sel, 2'd2);
        chk("t2a_data",   en_data, 16'd300);
        idle_clks(20);
        chk("t2_hold_sel",  cmd_if.uart_sel, 2'd2);
        chk("t2_hold_data", cmd_if.uart_data, 16'd300);
        send_byte(8'hA2, 1'b1);
        chk("t2_mid_data",  cmd_if.uart_data, 16'd300);
        send_byte(8'h03, 1'b1);
        send_byte(8'h84, 1'b1);
        chk("t2b_en_cnt", en_cnt, 2);
        chk("t2b_data",   en_data, 16'd900);
        chk("t2_errs",    frm_cnt + hdr_cnt + to_cnt, 0);

        // 3: bad header byte then a good frame.
        clear_mon();
        send_byte(8'h55, 1'b1);
        chk("t3_hdr_cnt",  hdr_cnt, 1);
        chk("t3_hdr_time", hdr_cyc, last_start + 155);
        chk("t3_en_none",  en_cnt, 0);
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h14, 1'b1);
        chk("t3_en_cnt",   en_cnt, 1);
        chk("t3_sel",      en_sel, 2'd1);
        chk("t3_data",     en_data, 16'd20);
        chk("t3_hdr_once", hdr_cnt, 1);

        // 4: framing error aborts the frame.
        clear_mon();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b0);
        idle_clks(40);
        chk("t4_frm_cnt", frm_cnt, 1);
        chk("t4_en_none", en_cnt, 0);
        chk("t4_busy",    busy, 1'b0);
        chk("t4_data_kept", cmd_if.uart_data, 16'd20);
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h28, 1'b1);
        chk("t4_en_cnt",  en_cnt, 1);
        chk("t4_data",    en_data, 16'd40);
        chk("t4_other_errs", hdr_cnt + to_cnt, 0);

        // 5: inter-byte timeout.
        clear_mon();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("t5_busy_pre", busy, 1'b1);
        idle_clks(700);
        chk("t5_to_cnt",   to_cnt, 1);
        chk("t5_to_time",  to_cyc, last_start + 155 + 640);
        chk("t5_busy",     busy, 1'b0);
        chk("t5_en_none",  en_cnt, 0);
        send_byte(8'hA1, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h1E, 1'b1);
        chk("t5_en_cnt",   en_cnt, 1);
        chk("t5_data",     en_data, 16'd30);
        chk("t5_other_errs", frm_cnt + hdr_cnt, 0);

        // 6: start-bit glitch, then reset in the middle of a frame.
        clear_mon();
        rx = 1'b0;
        idle_clks(4);
        rx = 1'b1;
        idle_clks(30);
        chk("t6_glitch_busy", busy, 1'b0);
        chk("t6_glitch_errs", frm_cnt + hdr_cnt + to_cnt + en_cnt, 0);
        send_byte(8'hA2, 1'b1);
        rx = 1'b0;
        idle_clks(16);
        rx = 1'b0;
        idle_clks(16);
        rx = 1'b0;
        idle_clks(8);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        chk("t6_rst_en",   cmd_if.uart_en,   1'b0);
        chk("t6_rst_sel",  cmd_if.uart_sel,  2'd0);
        chk("t6_rst_data", cmd_if.uart_data, 16'd0);
        chk("t6_rst_busy", busy,             1'b0);
        chk("t6_rst_errs", {frm_err, hdr_err, to_err}, 3'b000);
        idle_clks(3);
        reset = 1'b0;
        idle_clks(20);
        chk("t6_post_busy", busy, 1'b0);
        chk("t6_post_en",   en_cnt, 0);
        send_byte(8'hA2, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h64, 1'b1);
        chk("t6_en_cnt", en_cnt, 1);
        chk("t6_sel",    en_sel, 2'd2);
        chk("t6_data",   en_data, 16'd100);
        chk("t6_errs",   frm_cnt + hdr_cnt + to_cnt, 0);
        idle_clks(5);

        // Whole-run properties.
        chk("no_pulse_overlap",   overlap_cnt, 0);
        chk("no_change_w/o_en",   change_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
